avalon_ram_agent: RTL

AVALON_RAM_AGENT -- requirements
Module: avalon_ram_agent

---
 rtl/avalon_ram_agent_pkg.sv | 13 +
 rtl/avalon_ram_agent_if.sv | 21 ++
 rtl/avalon_ram_agent_ram.sv | 31 +++
 rtl/avalon_ram_agent.sv | 134 +++++++++++++
 4 files changed

// File: rtl/avalon_ram_agent_pkg.sv
// rtl/avalon_ram_agent_pkg.sv - shared types for the Avalon-MM RAM agent
package Types;
    typedef logic [31:0] word;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT,
        DONE
    } agent_state_e;

    localparam word BOUNDS_FILL = 32'hDEAD_BEEF;
endpackage

// File: rtl/avalon_ram_agent_if.sv
// rtl/avalon_ram_agent_if.sv - Avalon-MM read/write bus between host and RAM agent
interface AvalonMmRw;
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [3:0]  byteenable;
    Types::word  host_to_agent;
    Types::word  agent_to_host;
    logic        waitrequest;
    logic        readdatavalid;

    modport Host (
        output read, write, address, byteenable, host_to_agent,
        input  agent_to_host, waitrequest, readdatavalid
    );

    modport Agent (
        input  read, write, address, byteenable, host_to_agent,
        output agent_to_host, waitrequest, readdatavalid
    );
endinterface

// File: rtl/avalon_ram_agent_ram.sv
// rtl/avalon_ram_agent_ram.sv - single-port RAM, byte write enables, registered read
module ram_1rw_be
    import Types::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic [AW-1:0] addr_i,
    input  logic          re_i,
    input  logic [3:0]    we_i,
    input  word           wdata_i,
    output word           rdata_o
);
    word mem_q [DEPTH];
    word rdata_q;

    // rdata_q only moves on a read so it stays valid through any wait states
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/avalon_ram_agent.sv
// rtl/avalon_ram_agent.sv - Avalon-MM RAM agent with configurable wait states; RAM_AGENT_BOUNDS_EN enables bounds checking
module avalon_ram_agent
    import Types::*;
#(
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_WAIT   = 0
) (
    input logic      clk,
    input logic      rst,
    AvalonMmRw.Agent port
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [2:0] RD_LOAD = 3'(READ_LATENCY - 1);
    localparam logic [2:0] WR_LOAD = (WRITE_WAIT == 0) ? 3'd0 : 3'(WRITE_WAIT - 1);
`ifdef RAM_AGENT_BOUNDS_EN
    localparam logic OOB_EN = 1'b1;
`else
    localparam logic OOB_EN = 1'b0;
`endif

    agent_state_e  state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          is_rd_q, is_rd_d;
    logic          oob_q, oob_d;
    logic [AW-1:0] idx_q, idx_d;
    word           wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;

    logic [AW-1:0] in_idx;
    logic [AW-1:0] ram_addr;
    logic          in_oob;
    logic          ram_re;
    logic [3:0]    ram_we;
    logic          rdv;
    word           ram_rdata;

    // without bounds checking the upper address bits are simply dropped (wrap)
    assign in_idx = port.address[AW+1:2];
    assign in_oob = OOB_EN & ((port.address >> (AW + 2)) != 32'd0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            is_rd_q <= 1'b0;
            oob_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_rd_q <= is_rd_d;
            oob_q   <= oob_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    // cnt_q holds the wait cycles still owed; a wait state ends once it drains
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        is_rd_d = is_rd_q;
        oob_d   = oob_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        ram_re  = 1'b0;
        case (state_q)
            IDLE: begin
                if (port.write) begin
                    is_rd_d = 1'b0;
                    idx_d   = in_idx;
                    oob_d   = in_oob;
                    wdata_d = port.host_to_agent;
                    be_d    = port.byteenable;
                    cnt_d   = WR_LOAD;
                    state_d = (WR_LOAD == 3'd0) ? DONE : WR_WAIT;
                end else if (port.read) begin
                    is_rd_d = 1'b1;
                    idx_d   = in_idx;
                    oob_d   = in_oob;
                    ram_re  = 1'b1;
                    cnt_d   = RD_LOAD;
                    state_d = (RD_LOAD == 3'd0) ? DONE : RD_WAIT;
                end
            end
            RD_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (!port.read) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end else if (cnt_q <= 3'd1) begin
                    state_d = DONE;
                end
            end
            WR_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (!port.write) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end else if (cnt_q <= 3'd1) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // commit is gated by rst so a reset landing on DONE never writes
    assign ram_we   = (rst && state_q == DONE && !is_rd_q && !oob_q) ? be_q : 4'd0;
    assign ram_addr = (state_q == IDLE) ? in_idx : idx_q;
    assign rdv      = (state_q == DONE) && is_rd_q;

    assign port.waitrequest   = (port.read | port.write) && (state_q != DONE);
    assign port.readdatavalid = rdv;
    assign port.agent_to_host = rdv ? (oob_q ? BOUNDS_FILL : ram_rdata) : '0;

    ram_1rw_be #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clk),
        .addr_i  (ram_addr),
        .re_i    (ram_re),
        .we_i    (ram_we),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );
endmodule
